// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: sequential imem reads, in-order response FIFO with PC tags,
// valid/ready delivery to the control FSM, and redirect with drain of stale responses.
module instr_fetch_buffer #(
   parameter int unsigned          PC_WIDTH = 64,
   parameter int unsigned          DEPTH    = 2,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         redirect,
   input  logic [PC_WIDTH-1:0]          redirect_pc,
   output logic                         imem_req,
   output logic [PC_WIDTH-1:0]          imem_addr,
   input  logic                         imem_rvalid,
   input  logic [31:0]                  imem_rdata,
   output logic                         instr_valid,
   output logic [31:0]                  instr_out,
   output logic [PC_WIDTH-1:0]          instr_pc,
   input  logic                         instr_ready,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0]         instr;
      logic [PC_WIDTH-1:0] pc;
   } entry_t;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]    out_q, out_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    tag_rd_q, tag_rd_d;
   logic [PTR_W-1:0]    tag_wr_q, tag_wr_d;
   entry_t              data_q [DEPTH];
   entry_t              data_d [DEPTH];
   logic [PC_WIDTH-1:0] tag_q  [DEPTH];
   logic [PC_WIDTH-1:0] tag_d  [DEPTH];
   logic                head_valid_q, head_valid_d;
   entry_t              head_q, head_d;

   logic [SUM_W-1:0]    used_c;
   logic                credit_c;
   logic                rsp_ok_c;
   logic                push_c;
   logic                pop_c;

   // State register and all datapath flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         fetch_pc_q   <= RESET_PC;
         out_q        <= '0;
         cnt_q        <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         tag_rd_q     <= '0;
         tag_wr_q     <= '0;
         head_valid_q <= 1'b0;
         head_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         out_q        <= out_d;
         cnt_q        <= cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         tag_rd_q     <= tag_rd_d;
         tag_wr_q     <= tag_wr_d;
         head_valid_q <= head_valid_d;
         head_q       <= head_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end

   // Request issue: credit counts both buffered entries and reads still in flight
   always_comb begin
      used_c    = SUM_W'(cnt_q) + SUM_W'(out_q);
      credit_c  = used_c < SUM_W'(DEPTH);
      imem_req  = (state_q == ST_RUN) && credit_c && !redirect;
      imem_addr = fetch_pc_q;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  state_d = ST_RUN;
         ST_RUN: begin
            if (redirect && (out_d != '0)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (redirect)           state_d = ST_DRAIN;
            else if (out_d == '0)   state_d = ST_RUN;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Counters, PC, response FIFO and tag FIFO
   always_comb begin
      rsp_ok_c = imem_rvalid && (out_q != '0);
      push_c   = rsp_ok_c && (state_q == ST_RUN) && !redirect;
      pop_c    = head_valid_q && instr_ready && !redirect;

      fetch_pc_d = fetch_pc_q;
      out_d      = out_q;
      cnt_d      = cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      tag_rd_d   = tag_rd_q;
      tag_wr_d   = tag_wr_q;
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = data_q[i];
         tag_d[i]  = tag_q[i];
      end

      if (redirect) fetch_pc_d = redirect_pc & ~PC_WIDTH'(3);
      else if (imem_req) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);

      unique case ({imem_req, rsp_ok_c})
         2'b10:   out_d = out_q + CNT_W'(1);
         2'b01:   out_d = out_q - CNT_W'(1);
         default: out_d = out_q;
      endcase

      if (imem_req) begin
         tag_d[tag_wr_q] = fetch_pc_q;
         tag_wr_d        = tag_wr_q + PTR_W'(1);
      end

      if (push_c) begin
         data_d[wr_ptr_q] = '{instr: imem_rdata, pc: tag_q[tag_rd_q]};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         tag_rd_d         = tag_rd_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // Flush wins over everything else in the same cycle
      if (redirect) begin
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         tag_rd_d = '0;
         tag_wr_d = '0;
      end

      head_valid_d = (cnt_d != '0);
      head_d       = head_valid_d ? data_d[rd_ptr_d] : '0;
   end

   assign instr_valid = head_valid_q;
   assign instr_out   = head_q.instr;
   assign instr_pc    = head_q.pc;
   assign outstanding = out_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: in-order latency memory, transaction-level PC model,
// per-cycle output checks plus hand-computed expectations for each directed scenario.
module tb_instr_fetch_buffer;

   localparam int unsigned PW = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          redirect = 1'b0;
   logic [PW-1:0] redirect_pc = '0;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic          imem_rvalid = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic          instr_valid;
   logic [31:0]   instr_out;
   logic [PW-1:0] instr_pc;
   logic          instr_ready = 1'b0;
   logic [1:0]    outstanding;

   instr_fetch_buffer #(.PC_WIDTH(PW), .DEPTH(2), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
      .instr_pc(instr_pc), .instr_ready(instr_ready), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] addr;
      int            due;
   } mreq_t;

   mreq_t         mem_q[$];
   logic [PW-1:0] req_log[$];
   logic [PW-1:0] pop_log[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            lat = 1;
   int            since_rel = 0;
   int            first_valid_at = -1;
   logic          inj_rvalid = 1'b0;
   logic          draining = 1'b0;
   logic          prev_redirect = 1'b0;
   logic [PW-1:0] exp_fetch_pc = '0;
   logic [PW-1:0] exp_deliver_pc = '0;

   function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
      return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [PW-1:0] at_or_ones(input logic [PW-1:0] q[$], input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return '1;
   endfunction

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive memory response, compare outputs against the model, advance the model
   task automatic step();
      logic rv;
      logic req;
      logic pop;
      rv = 1'b0;
      if (inj_rvalid) begin
         rv = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rv = 1'b1;
         imem_rdata = mem_word(mem_q[0].addr);
      end
      imem_rvalid = rv;
      #1;
      if (mem_q.size() == 0) draining = 1'b0;
      chk("outstanding", PW'(outstanding), PW'(mem_q.size()));
      if (redirect) chk("req_in_redirect", PW'(imem_req), '0);
      if (draining) chk("req_in_drain", PW'(imem_req), '0);
      if (prev_redirect) chk("valid_after_redirect", PW'(instr_valid), '0);
      req = imem_req;
      pop = instr_valid && instr_ready && !redirect;
      if (req) begin
         chk("imem_addr", imem_addr, exp_fetch_pc);
         req_log.push_back(imem_addr);
      end
      if (pop) begin
         chk("instr_pc", instr_pc, exp_deliver_pc);
         chk("instr_out", PW'(instr_out), PW'(mem_word(exp_deliver_pc)));
         pop_log.push_back(instr_pc);
      end
      if (instr_valid && first_valid_at < 0) first_valid_at = since_rel;
      if (rv && !inj_rvalid) mem_q.delete(0);
      if (req) mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      if (redirect) begin
         exp_fetch_pc   = redirect_pc & ~PW'(3);
         exp_deliver_pc = redirect_pc & ~PW'(3);
         if (mem_q.size() > 0) draining = 1'b1;
      end else begin
         if (req) exp_fetch_pc = exp_fetch_pc + PW'(4);
         if (pop) exp_deliver_pc = exp_deliver_pc + PW'(4);
      end
      prev_redirect = redirect;
      @(posedge clk);
      cyc++;
      since_rel++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect_to(input logic [PW-1:0] pc);
      redirect = 1'b1;
      redirect_pc = pc;
      step();
      redirect = 1'b0;
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before any clock edge
   task automatic do_reset();
      #3 reset = 1'b0;
      #1;
      chk("rst_imem_req", PW'(imem_req), '0);
      chk("rst_imem_addr", imem_addr, '0);
      chk("rst_instr_valid", PW'(instr_valid), '0);
      chk("rst_instr_out", PW'(instr_out), '0);
      chk("rst_instr_pc", instr_pc, '0);
      chk("rst_outstanding", PW'(outstanding), '0);
      mem_q.delete();
      imem_rvalid = 1'b0;
      inj_rvalid = 1'b0;
      redirect = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_fetch_pc = '0;
      exp_deliver_pc = '0;
      draining = 1'b0;
      prev_redirect = 1'b0;
      since_rel = 0;
      first_valid_at = -1;
      req_log.delete();
      pop_log.delete();
   endtask

   task automatic wait_out2();
      for (int i = 0; i < 20 && outstanding != 2'd2; i++) step();
      chk("reach_outstanding_2", PW'(outstanding), PW'(2));
   endtask

   initial begin
      int ridx;
      int pidx;
      @(negedge clk);
      @(negedge clk);

      // 1: latency 1, always ready
      do_reset();
      lat = 1;
      instr_ready = 1'b1;
      run(12);
      chk("t1_req0", at_or_ones(req_log, 0), 64'h0);
      chk("t1_req1", at_or_ones(req_log, 1), 64'h4);
      chk("t1_req2", at_or_ones(req_log, 2), 64'h8);
      chk("t1_first_valid_cycle", PW'(first_valid_at), PW'(3));
      chk("t1_first_pop_pc", at_or_ones(pop_log, 0), 64'h0);

      // 2: consumer stalled, FIFO fills, credit stops requests; stray rvalid ignored
      do_reset();
      lat = 1;
      instr_ready = 1'b0;
      run(8);
      chk("t2_req_count", PW'(req_log.size()), PW'(2));
      chk("t2_req1", at_or_ones(req_log, 1), 64'h4);
      #1;
      chk("t2_req_held", PW'(imem_req), '0);
      chk("t2_head_pc", instr_pc, 64'h0);
      inj_rvalid = 1'b1;
      step();
      inj_rvalid = 1'b0;
      run(2);
      instr_ready = 1'b1;
      run(8);
      chk("t2_pop0", at_or_ones(pop_log, 0), 64'h0);
      chk("t2_pop1", at_or_ones(pop_log, 1), 64'h4);
      chk("t2_req2", at_or_ones(req_log, 2), 64'h8);

      // 3: latency 3, redirect with two reads in flight
      do_reset();
      lat = 3;
      instr_ready = 1'b1;
      wait_out2();
      ridx = req_log.size();
      pidx = pop_log.size();
      redirect_to(64'h100);
      run(15);
      chk("t3_req_after", at_or_ones(req_log, ridx), 64'h100);
      chk("t3_pop_after", at_or_ones(pop_log, pidx), 64'h100);

      // 4: redirect together with ready while FIFO holds two entries
      do_reset();
      lat = 1;
      instr_ready = 1'b0;
      run(8);
      instr_ready = 1'b1;
      pidx = pop_log.size();
      redirect_to(64'h40);
      chk("t4_no_pop", PW'(pop_log.size()), PW'(pidx));
      #1;
      chk("t4_valid_low", PW'(instr_valid), '0);
      run(8);
      chk("t4_pop_after", at_or_ones(pop_log, pidx), 64'h40);

      // 5: second redirect while draining
      do_reset();
      lat = 3;
      instr_ready = 1'b1;
      wait_out2();
      pidx = pop_log.size();
      redirect_to(64'h100);
      redirect_to(64'h200);
      run(15);
      chk("t5_pop_after", at_or_ones(pop_log, pidx), 64'h200);

      // 6: unaligned redirect, PC wrap, reset mid-fetch
      do_reset();
      lat = 1;
      instr_ready = 1'b1;
      run(5);
      ridx = req_log.size();
      redirect_to(64'h103);
      #1;
      chk("t6_addr_aligned", imem_addr, 64'h100);
      run(6);
      chk("t6_req_after", at_or_ones(req_log, ridx), 64'h100);
      pidx = pop_log.size();
      redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
      run(12);
      chk("t6_wrap_pop0", at_or_ones(pop_log, pidx), 64'hFFFF_FFFF_FFFF_FFF8);
      chk("t6_wrap_pop2", at_or_ones(pop_log, pidx + 2), 64'h0);
      do_reset();
      run(6);
      chk("t6_restart_req", at_or_ones(req_log, 0), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
